updown_counter_hex: RTL and testbench



---
 rtl/updown_counter_hex.sv | 99 +++++++++
 tb/tb_updown_counter_hex.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_hex.sv
// Up/down modulo counter with load, terminal-count pulse and registered
// active-low seven-segment drivers, one per hex nibble of the count.
module updown_counter_hex #(
    parameter int unsigned        WIDTH   = 8,
    parameter logic [WIDTH-1:0]   MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic                      clk,
    input  logic                      clear_b,
    input  logic                      enable,
    input  logic                      up,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_val,
    output logic [WIDTH-1:0]          q,
    output logic                      tc,
    output logic [7*(WIDTH/4)-1:0]    hex
);

    localparam int unsigned NDIG = WIDTH / 4;
    localparam logic [6:0]  SEG_ZERO = 7'b1000000;

    logic [WIDTH-1:0]  q_q, q_d;
    logic              tc_q, tc_d;
    logic [7*NDIG-1:0] hex_q, hex_d;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        // NOTE: defaults first so every path assigns q_d/tc_d and no latch is inferred.
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            q_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (enable) begin
            if (up) begin
                // An out-of-range count falls back to 0 like a normal wrap.
                if (q_q >= MAX_VAL) begin
                    q_d  = '0;
                    tc_d = (q_q == MAX_VAL);
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    q_d  = MAX_VAL;
                    tc_d = 1'b1;
                end else if (q_q > MAX_VAL) begin
                    q_d = MAX_VAL;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // Display is decoded from the registered count, so it trails q by one clock.
    always_comb begin
        hex_d = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            hex_d[7*i +: 7] = seg7(q_q[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
            hex_q <= {NDIG{SEG_ZERO}};
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            q_q   <= q_d;
            tc_q  <= tc_d;
            hex_q <= hex_d;
        end
    end

    assign q   = q_q;
    assign tc  = tc_q;
    assign hex = hex_q;

endmodule

// File: tb/tb_updown_counter_hex.sv
// Directed bench for updown_counter_hex: three instances (8-bit full range,
// 8-bit modulo 60, 16-bit modulo 10000) sharing clock and reset.
module tb_updown_counter_hex;

    logic clk = 1'b0;
    logic clear_b;
    always #5 clk = ~clk;

    logic        en_a, up_a, ld_a;
    logic [7:0]  lv_a, q_a;
    logic        tc_a;
    logic [13:0] hex_a;

    logic        en_b, up_b, ld_b;
    logic [7:0]  lv_b, q_b;
    logic        tc_b;
    logic [13:0] hex_b;

    logic        en_c, up_c, ld_c;
    logic [15:0] lv_c, q_c;
    logic        tc_c;
    logic [27:0] hex_c;

    updown_counter_hex #(.WIDTH(8), .MAX_VAL(8'd255)) dut_a (
        .clk(clk), .clear_b(clear_b), .enable(en_a), .up(up_a), .load(ld_a),
        .load_val(lv_a), .q(q_a), .tc(tc_a), .hex(hex_a));

    updown_counter_hex #(.WIDTH(8), .MAX_VAL(8'd59)) dut_b (
        .clk(clk), .clear_b(clear_b), .enable(en_b), .up(up_b), .load(ld_b),
        .load_val(lv_b), .q(q_b), .tc(tc_b), .hex(hex_b));

    updown_counter_hex #(.WIDTH(16), .MAX_VAL(16'd9999)) dut_c (
        .clk(clk), .clear_b(clear_b), .enable(en_c), .up(up_c), .load(ld_c),
        .load_val(lv_c), .q(q_c), .tc(tc_c), .hex(hex_c));

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       ld;
        logic       en;
        logic       up;
        logic [7:0] lv;
        logic [7:0] q;
        logic       tc;
    } vec_t;

    vec_t vecs [21];

    function automatic logic [13:0] hex8(input logic [7:0] v);
        return {seg_tbl[v[7:4]], seg_tbl[v[3:0]]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] prev;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd0,   8'd59,  1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd0,   8'd58,  1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd0,   8'd57,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd200, 8'd59,  1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h1A,  8'h1A,  1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'd0,   8'h1A,  1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'd0,   8'h1B,  1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h37,  8'h37,  1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'd0,   8'h37,  1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'd0,   8'h37,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'h37,  1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'h37,  1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'h37,  1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'd0,   8'h36,  1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'd60,  8'd59,  1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 8'd0,   8'd59,  1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 8'd59,  8'd59,  1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 8'd0,   8'd58,  1'b0};

        clear_b = 1'b0;
        en_a = 1'b1; up_a = 1'b1; ld_a = 1'b0; lv_a = '0;
        en_b = 1'b0; up_b = 1'b0; ld_b = 1'b0; lv_b = '0;
        en_c = 1'b0; up_c = 1'b0; ld_c = 1'b0; lv_c = '0;

        // Outputs must hold reset values across edges while clear_b is low.
        step();
        step();
        check("reset_q_a",   32'(q_a),   32'd0);
        check("reset_tc_a",  32'(tc_a),  32'd0);
        check("reset_hex_a", 32'(hex_a), 32'(hex8(8'h00)));
        check("reset_q_c",   32'(q_c),   32'd0);
        check("reset_hex_c", 32'(hex_c), 32'({4{7'b1000000}}));
        en_a = 1'b0;
        clear_b = 1'b1;

        prev = 8'd0;
        for (int i = 0; i < 21; i++) begin
            ld_b = vecs[i].ld;
            en_b = vecs[i].en;
            up_b = vecs[i].up;
            lv_b = vecs[i].lv;
            step();
            check($sformatf("vec%0d_q", i),   32'(q_b),   32'(vecs[i].q));
            check($sformatf("vec%0d_tc", i),  32'(tc_b),  32'(vecs[i].tc));
            check($sformatf("vec%0d_hex", i), 32'(hex_b), 32'(hex8(prev)));
            prev = vecs[i].q;
        end
        ld_b = 1'b0;
        en_b = 1'b0;
        check("hold_a_during_table", 32'(q_a), 32'd0);

        // Full-range wrap: 256 enabled clocks from 0 return to 0 with one tc.
        en_a = 1'b1;
        up_a = 1'b1;
        prev = 8'd0;
        for (int i = 0; i < 256; i++) begin
            step();
            check($sformatf("wrap_q_%0d", i),   32'(q_a),   32'((i + 1) % 256));
            check($sformatf("wrap_tc_%0d", i),  32'(tc_a),  32'(i == 255));
            check($sformatf("wrap_hex_%0d", i), 32'(hex_a), 32'(hex8(prev)));
            prev = 8'(i + 1);
        end
        check("wrap_hex_ff", 32'(hex_a), 32'({7'b0001110, 7'b0001110}));
        en_a = 1'b0;
        step();
        check("wrap_tc_drop", 32'(tc_a), 32'd0);

        // 16-bit decade-style counter around 9999.
        ld_c = 1'b1; en_c = 1'b1; up_c = 1'b1; lv_c = 16'd9998;
        step();
        check("c_load_q", 32'(q_c), 32'd9998);
        ld_c = 1'b0;
        step();
        check("c_q_9999",  32'(q_c),  32'd9999);
        check("c_tc_9999", 32'(tc_c), 32'd0);
        step();
        check("c_wrap_q",  32'(q_c),  32'd0);
        check("c_wrap_tc", 32'(tc_c), 32'd1);
        check("c_hex_270f", 32'(hex_c),
              32'({seg_tbl[2], seg_tbl[7], seg_tbl[0], seg_tbl[15]}));
        en_c = 1'b0;

        // Asynchronous clear mid-cycle while counting.
        ld_a = 1'b1; lv_a = 8'h42;
        step();
        check("a_load_42", 32'(q_a), 32'h42);
        ld_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
        #2 clear_b = 1'b0;
        #1;
        check("async_q_a",   32'(q_a),   32'd0);
        check("async_tc_a",  32'(tc_a),  32'd0);
        check("async_hex_a", 32'(hex_a), 32'(hex8(8'h00)));
        check("async_q_c",   32'(q_c),   32'd0);
        #1 clear_b = 1'b1;
        step();
        check("post_clear_q", 32'(q_a), 32'd1);
        step();
        check("post_clear_q2",  32'(q_a),   32'd2);
        check("post_clear_hex", 32'(hex_a), 32'(hex8(8'h01)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
